// File: rtl/uart_rx_out_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_out_fifo
//  Purpose  : Output stage of the UART receive path. Buffers received words
//             together with their line-error flags in a DEPTH-entry FIFO and
//             presents them on a valid/ready handshake. Line errors and FIFO
//             overflow are reported at push time on a registered one-cycle
//             error strobe.
//  Options  : UART_OUT_OVF_CNT_EN - when defined, builds a saturating overflow
//             event counter on ovf_cnt; otherwise ovf_cnt is tied to zero.
//             The port list is the same in both builds.
//  Ports    :
//    clk          in   rising-edge clock
//    rst_n        in   asynchronous active-low reset
//    flush        in   synchronous clear of FIFO contents and overflow count
//    in_data      in   received word
//    in_error     in   line-error flags for in_data (bit0 parity, bit1 framing)
//    in_valid     in   push strobe (no backpressure to the RX core)
//    out          out  head-of-FIFO data
//    out_error    out  line-error flags stored with the head word
//    valid_out    out  FIFO not empty
//    ready_out    in   consumer accepts the head when high with valid_out
//    error        out  {overflow, line flags}, meaningful with valid_error
//    valid_error  out  one-cycle error strobe
//    count        out  current occupancy
//    full         out  count == DEPTH
//    ovf_cnt      out  saturating overflow count
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_out_fifo #(
  parameter int WIDTH_DATABITS = 8,
  parameter int WIDTH_ERROR    = 2,
  parameter int DEPTH          = 8,
  parameter int OVF_CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [WIDTH_DATABITS-1:0]    in_data,
  input  logic [WIDTH_ERROR-1:0]       in_error,
  input  logic                         in_valid,
  output logic [WIDTH_DATABITS-1:0]    out,
  output logic [WIDTH_ERROR-1:0]       out_error,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [WIDTH_ERROR:0]         error,
  output logic                         valid_error,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [OVF_CNT_W-1:0]         ovf_cnt
);

  localparam int C_PTR_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = $clog2(DEPTH+1);
  localparam int C_ENTRY_W = WIDTH_ERROR + WIDTH_DATABITS;

  // Storage: each entry is {in_error, in_data}; not reset.
  logic [C_ENTRY_W-1:0] mem_q [DEPTH];
  logic [C_ENTRY_W-1:0] w_head;

  logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_CNT_W-1:0]   count_q,  count_d;
  logic [WIDTH_ERROR:0] err_q,    err_d;
  logic                 err_vld_q, err_vld_d;

  logic w_pop;
  logic w_push;
  logic w_ovf;

  assign valid_out = (count_q != '0);
  assign full      = (count_q == C_CNT_W'(DEPTH));
  assign count     = count_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when the consumer is draining the head.
  assign w_pop  = valid_out & ready_out;
  assign w_push = in_valid & (~full | w_pop);
  assign w_ovf  = in_valid & full & ~w_pop;

  assign w_head    = mem_q[rd_ptr_q];
  assign out       = w_head[WIDTH_DATABITS-1:0];
  assign out_error = w_head[C_ENTRY_W-1:WIDTH_DATABITS];

  assign error       = err_q;
  assign valid_error = err_vld_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    err_d     = '0;
    err_vld_d = 1'b0;
    if (flush) begin
      // Flush wins over everything: concurrent push is dropped silently.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_W'(1);
        2'b01:   count_d = count_q - C_CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (w_ovf) begin
        err_vld_d = 1'b1;
        err_d     = {1'b1, in_error};
      end else if (w_push && (in_error != '0)) begin
        err_vld_d = 1'b1;
        err_d     = {1'b0, in_error};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      mem_q[wr_ptr_q] <= {in_error, in_data};
    end
  end

`ifdef UART_OUT_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (flush) begin
      ovf_cnt_d = '0;
    end else if (w_ovf && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_out_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_out_fifo
//  Purpose  : Self-checking bench for uart_rx_out_fifo (default parameters).
//             Table-driven vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_out_fifo;

`ifdef UART_OUT_OVF_CNT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic [1:0] in_error;
  logic       in_valid;
  logic [7:0] out;
  logic [1:0] out_error;
  logic       valid_out;
  logic       ready_out;
  logic [2:0] error;
  logic       valid_error;
  logic [3:0] count;
  logic       full;
  logic [7:0] ovf_cnt;

  uart_rx_out_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_error    (in_error),
    .in_valid    (in_valid),
    .out         (out),
    .out_error   (out_error),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .error       (error),
    .valid_error (valid_error),
    .count       (count),
    .full        (full),
    .ovf_cnt     (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic [1:0] e;
    logic       rdy;
    logic       ev;
    logic [7:0] eout;
    logic [1:0] eoe;
    logic [3:0] ecnt;
    logic       efull;
    logic       everr;
    logic [2:0] eerr;
    logic [7:0] eovf;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [7:0] d,
                              input logic [1:0] e, input logic rdy, input logic ev,
                              input logic [7:0] eout, input logic [1:0] eoe,
                              input logic [3:0] ecnt, input logic efull,
                              input logic everr, input logic [2:0] eerr,
                              input logic [7:0] eovf);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.e = e; v.rdy = rdy;
    v.ev = ev; v.eout = eout; v.eoe = eoe; v.ecnt = ecnt; v.efull = efull;
    v.everr = everr; v.eerr = eerr; v.eovf = eovf;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [7:0] d,
                       input logic [1:0] e, input logic rdy);
    flush = fl; in_valid = iv; in_data = d; in_error = e; ready_out = rdy;
  endtask

  // Inputs applied at a falling edge; results checked at the next falling edge.
  task automatic step_vec(input vec_t v, input int idx);
    drive(v.fl, v.iv, v.d, v.e, v.rdy);
    @(negedge clk);
    chk($sformatf("v%0d.valid_out", idx), valid_out, v.ev);
    chk($sformatf("v%0d.count", idx), count, v.ecnt);
    chk($sformatf("v%0d.full", idx), full, v.efull);
    chk($sformatf("v%0d.valid_error", idx), valid_error, v.everr);
    if (v.everr) chk($sformatf("v%0d.error", idx), error, v.eerr);
    chk($sformatf("v%0d.ovf_cnt", idx), ovf_cnt, v.eovf);
    if (v.ev) begin
      chk($sformatf("v%0d.out", idx), out, v.eout);
      chk($sformatf("v%0d.out_error", idx), out_error, v.eoe);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  logic [9:0] mq[$];
  logic [7:0] e1;
  logic [7:0] d_l;
  logic [1:0] e_l;
  logic       iv_l, rdy_l, mpop, mpush, movf, exp_verr;
  logic [2:0] exp_err;
  int         wi, cyc;

  initial begin
    e1 = 8'(OVF_EN);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst.count", count, 0);
    chk("rst.full", full, 0);
    chk("rst.valid_out", valid_out, 0);
    chk("rst.valid_error", valid_error, 0);
    chk("rst.error", error, 0);
    chk("rst.ovf_cnt", ovf_cnt, 0);
    rst_n = 1'b1;

    // ---- table: basic push/pop, fill/overflow, push+pop while full ----
    vt.push_back(mk(0,1,8'h55,2'b00,1, 1,8'h55,0,1,0, 0,3'b000,0));
    vt.push_back(mk(0,0,8'h00,2'b00,1, 0,8'h00,0,0,0, 0,3'b000,0));
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(0,1,8'(k),2'b00,0, 1,8'h01,0,4'(k),(k == 8), 0,3'b000,0));
    vt.push_back(mk(0,1,8'h09,2'b10,0, 1,8'h01,0,8,1, 1,3'b110,e1));
    vt.push_back(mk(0,0,8'h00,2'b00,0, 1,8'h01,0,8,1, 0,3'b000,e1));
    vt.push_back(mk(0,1,8'hA5,2'b00,1, 1,8'h02,0,8,1, 0,3'b000,e1));
    for (int k = 3; k <= 8; k++)
      vt.push_back(mk(0,0,8'h00,2'b00,1, 1,8'(k),0,4'(10-k),0, 0,3'b000,e1));
    vt.push_back(mk(0,0,8'h00,2'b00,1, 1,8'hA5,0,1,0, 0,3'b000,e1));
    vt.push_back(mk(0,0,8'h00,2'b00,1, 0,8'h00,0,0,0, 0,3'b000,e1));
    foreach (vt[i]) step_vec(vt[i], i);

    // ---- stream 20 words across the pointer wrap, word 13 has parity error ----
    wi = 1;
    cyc = 0;
    mq.delete();
    while ((wi <= 20 || mq.size() != 0) && cyc < 80) begin
      iv_l  = (wi <= 20);
      d_l   = 8'h40 + 8'(wi);
      e_l   = (wi == 13) ? 2'b01 : 2'b00;
      rdy_l = ((cyc % 3) != 2);
      drive(1'b0, iv_l, d_l, e_l, rdy_l);
      mpop  = (mq.size() != 0) && rdy_l;
      mpush = iv_l && ((mq.size() < 8) || mpop);
      movf  = iv_l && (mq.size() == 8) && !mpop;
      exp_verr = movf || (mpush && (e_l != 2'b00));
      exp_err  = movf ? {1'b1, e_l} : {1'b0, e_l};
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back({e_l, d_l});
      if (iv_l) wi++;
      @(negedge clk);
      chk("wrap.count", count, mq.size());
      chk("wrap.valid_out", valid_out, (mq.size() != 0));
      chk("wrap.valid_error", valid_error, exp_verr);
      if (exp_verr) chk("wrap.error", error, exp_err);
      if (mq.size() != 0) begin
        chk("wrap.out", out, mq[0][7:0]);
        chk("wrap.out_error", out_error, mq[0][9:8]);
      end
      cyc++;
    end
    if (cyc >= 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap.drain: actual %0d cycles required < 80", cyc);
    end
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);

    // ---- flush with concurrent push ----
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 8'hC0 + 8'(k), 2'b00, 1'b0);
      @(negedge clk);
    end
    chk("flush.pre_count", count, 3);
    drive(1'b1, 1'b1, 8'hEE, 2'b11, 1'b0);
    @(negedge clk);
    chk("flush.count", count, 0);
    chk("flush.valid_out", valid_out, 0);
    chk("flush.full", full, 0);
    chk("flush.valid_error", valid_error, 0);
    chk("flush.ovf_cnt", ovf_cnt, 0);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    @(negedge clk);
    chk("flush.post_valid_error", valid_error, 0);
    chk("flush.post_count", count, 0);

    // ---- reset mid-stream ----
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, 1'b1, 8'h10 + 8'(k), 2'b00, 1'b0);
      @(negedge clk);
    end
    chk("rstm.count8", count, 8);
    chk("rstm.ovf_cnt3", ovf_cnt, 8'(3 * OVF_EN));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
      @(negedge clk);
    end
    chk("rstm.count5", count, 5);
    chk("rstm.head", out, 8'h13);
    drive(1'b0, 1'b1, 8'h77, 2'b01, 1'b1);
    @(negedge clk);
    chk("rstm.pre_valid_error", valid_error, 1);
    chk("rstm.pre_error", error, 3'b001);
    chk("rstm.pre_count", count, 5);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm.count", count, 0);
    chk("rstm.valid_out", valid_out, 0);
    chk("rstm.full", full, 0);
    chk("rstm.valid_error", valid_error, 0);
    chk("rstm.error", error, 0);
    chk("rstm.ovf_cnt", ovf_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstm.post_count", count, 0);
    chk("rstm.post_valid_out", valid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
